// File: rtl/packet_filter_fifo_if.sv
// Beat-stream bundle between the header parser, the packet filter FIFO and its consumer.
// The master side is the parser/consumer. The slave side is the filter FIFO.
interface packet_filter_fifo_if #(
  parameter int WIDTH_DATA_BYTES  = 8,
  parameter int WIDTH_HDR_A_BYTES = 6,
  parameter int WIDTH_HDR_B_BYTES = 4
);
  logic                           in_valid;
  logic                           in_sop;
  logic                           in_eop;
  logic [WIDTH_DATA_BYTES-1:0]    in_byteen;
  logic [WIDTH_DATA_BYTES*8-1:0]  in_data;
  logic [WIDTH_HDR_A_BYTES*8-1:0] in_headerA;
  logic [WIDTH_HDR_B_BYTES*8-1:0] in_headerB;

  logic                           out_valid;
  logic                           out_ready;
  logic                           out_sop;
  logic                           out_eop;
  logic [WIDTH_DATA_BYTES-1:0]    out_byteen;
  logic [WIDTH_DATA_BYTES*8-1:0]  out_data;
  logic [WIDTH_HDR_B_BYTES*8-1:0] out_headerB;

  modport master (
    output in_valid, in_sop, in_eop, in_byteen, in_data, in_headerA, in_headerB,
    output out_ready,
    input  out_valid, out_sop, out_eop, out_byteen, out_data, out_headerB
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_byteen, in_data, in_headerA, in_headerB,
    input  out_ready,
    output out_valid, out_sop, out_eop, out_byteen, out_data, out_headerB
  );
endinterface

// File: rtl/packet_filter_fifo.sv
// Address filter plus a first-word-fall-through packet FIFO behind a one-beat stage register.
// state   | meaning
// IDLE    | between packets, waiting for sop
// ACCEPT  | storing beats of an admitted packet
// DISCARD | dropping beats until eop (or a fresh sop)
module packet_filter_fifo #(
  parameter int WIDTH_DATA_BYTES  = 8,
  parameter int WIDTH_HDR_A_BYTES = 6,
  parameter int WIDTH_HDR_B_BYTES = 4,
  parameter int FIFO_DEPTH        = 16,
  parameter int MAX_PKT_BEATS     = 8
) (
  input  logic                               clk_host,
  input  logic                               rst_n,
  packet_filter_fifo_if.slave                pkt,
  input  logic                               cfg_match_en,
  input  logic [WIDTH_HDR_A_BYTES*8-1:0]     cfg_match_addr,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic [15:0]                        cnt_accepted,
  output logic [15:0]                        cnt_drop_filter,
  output logic [15:0]                        cnt_drop_full,
  output logic [15:0]                        cnt_truncated
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(MAX_PKT_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_DISCARD} state_t;

  typedef struct packed {
    logic                           sop;
    logic                           eop;
    logic [WIDTH_DATA_BYTES-1:0]    be;
    logic [WIDTH_DATA_BYTES*8-1:0]  data;
    logic [WIDTH_HDR_B_BYTES*8-1:0] hdrb;
  } entry_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   beat_cnt;
  entry_t          stg;
  logic            stg_vld;
  entry_t          mem [FIFO_DEPTH];
  entry_t          head, wr_entry;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   fifo_cnt;

  logic sop_in, filt_rej, space_rej, admit;
  logic take, take_eop, trunc_max, flush_early, fifo_wr, pop;

  assign fifo_level = fifo_cnt + {{AW{1'b0}}, stg_vld};

  // Admission decision; cfg_* only matter on the sop beat.
  always_comb begin
    sop_in    = pkt.in_valid && pkt.in_sop;
    filt_rej  = cfg_match_en && (pkt.in_headerA != cfg_match_addr) && (pkt.in_headerA != '1);
    space_rej = (LW'(FIFO_DEPTH) - fifo_level) < LW'(MAX_PKT_BEATS);
    admit     = sop_in && !filt_rej && !space_rej;
  end

  always_ff @(posedge clk_host or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sop_in) begin
      if (!admit)          state_nxt = S_DISCARD;
      else if (pkt.in_eop) state_nxt = S_IDLE;
      else                 state_nxt = S_ACCEPT;
    end else if (pkt.in_valid) begin
      case (state)
        S_ACCEPT: begin
          if (pkt.in_eop)     state_nxt = S_IDLE;
          else if (trunc_max) state_nxt = S_DISCARD;
        end
        S_DISCARD: if (pkt.in_eop) state_nxt = S_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    trunc_max   = (state == S_ACCEPT) && pkt.in_valid && !pkt.in_sop && !pkt.in_eop &&
                  (beat_cnt == BW'(MAX_PKT_BEATS - 1));
    take        = admit || ((state == S_ACCEPT) && pkt.in_valid && !pkt.in_sop);
    take_eop    = pkt.in_eop || trunc_max;
    // Any sop closes off a half-built packet still sitting in the stage.
    flush_early = stg_vld && !stg.eop && sop_in;
    fifo_wr     = stg_vld && (stg.eop || sop_in || take);
    wr_entry     = stg;
    wr_entry.eop = stg.eop || flush_early;
  end

  assign pop = pkt.out_valid && pkt.out_ready;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk_host or negedge rst_n) begin
    if (!rst_n) begin
      stg             <= '0;
      stg_vld         <= 1'b0;
      beat_cnt        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      cnt_accepted    <= '0;
      cnt_drop_filter <= '0;
      cnt_drop_full   <= '0;
      cnt_truncated   <= '0;
    end else begin
      if (take) begin
        stg_vld  <= 1'b1;
        stg.sop  <= pkt.in_sop;
        stg.eop  <= take_eop;
        stg.be   <= pkt.in_byteen;
        stg.data <= pkt.in_data;
        stg.hdrb <= pkt.in_headerB;
      end else if (fifo_wr) begin
        stg_vld  <= 1'b0;
      end

      if (admit)     beat_cnt <= BW'(1);
      else if (take) beat_cnt <= beat_cnt + 1'b1;

      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase

      cnt_accepted    <= sat_inc(cnt_accepted, admit);
      cnt_drop_filter <= sat_inc(cnt_drop_filter, sop_in && filt_rej);
      cnt_drop_full   <= sat_inc(cnt_drop_full, sop_in && !filt_rej && space_rej);
      cnt_truncated   <= sat_inc(cnt_truncated, trunc_max || flush_early);
    end
  end

  always_ff @(posedge clk_host) begin
    if (fifo_wr) mem[wr_ptr] <= wr_entry;
  end

  assign head            = mem[rd_ptr];
  assign pkt.out_valid   = (fifo_cnt != '0);
  assign pkt.out_sop     = pkt.out_valid && head.sop;
  assign pkt.out_eop     = pkt.out_valid && head.eop;
  assign pkt.out_byteen  = pkt.out_valid ? head.be   : '0;
  assign pkt.out_data    = pkt.out_valid ? head.data : '0;
  assign pkt.out_headerB = pkt.out_valid ? head.hdrb : '0;
endmodule

// File: tb/tb_packet_filter_fifo.sv
// Directed bench for packet_filter_fifo: driver pushes expected beats, a negedge monitor pops and compares.
module tb_packet_filter_fifo;
  localparam int WDB = 8, WHA = 6, WHB = 4, DEPTH = 16, MAXB = 8, LW = 5;

  logic clk_host = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_host = ~clk_host;

  packet_filter_fifo_if #(.WIDTH_DATA_BYTES(WDB), .WIDTH_HDR_A_BYTES(WHA),
                          .WIDTH_HDR_B_BYTES(WHB)) bus ();

  logic            cfg_match_en;
  logic [WHA*8-1:0] cfg_match_addr;
  logic [LW-1:0]   fifo_level;
  logic [15:0]     cnt_accepted, cnt_drop_filter, cnt_drop_full, cnt_truncated;

  packet_filter_fifo #(.WIDTH_DATA_BYTES(WDB), .WIDTH_HDR_A_BYTES(WHA), .WIDTH_HDR_B_BYTES(WHB),
                       .FIFO_DEPTH(DEPTH), .MAX_PKT_BEATS(MAXB)) dut (
    .clk_host        (clk_host),
    .rst_n           (rst_n),
    .pkt             (bus.slave),
    .cfg_match_en    (cfg_match_en),
    .cfg_match_addr  (cfg_match_addr),
    .fifo_level      (fifo_level),
    .cnt_accepted    (cnt_accepted),
    .cnt_drop_filter (cnt_drop_filter),
    .cnt_drop_full   (cnt_drop_full),
    .cnt_truncated   (cnt_truncated)
  );

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [7:0]  be;
    logic [63:0] data;
    logic [31:0] hdrb;
  } beat_t;

  beat_t exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  int e_acc = 0, e_filt = 0, e_full = 0, e_trunc = 0;

  always @(negedge clk_host) begin
    beat_t a, e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      a.sop  = bus.out_sop;
      a.eop  = bus.out_eop;
      a.be   = bus.out_byteen;
      a.data = bus.out_data;
      a.hdrb = bus.out_headerB;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL out_beat unexpected: got sop=%b eop=%b be=%h data=%h hdrB=%h, want nothing",
                 a.sop, a.eop, a.be, a.data, a.hdrb);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_miss++;
          $display("FAIL out_beat: got sop=%b eop=%b be=%h data=%h hdrB=%h, want sop=%b eop=%b be=%h data=%h hdrB=%h",
                   a.sop, a.eop, a.be, a.data, a.hdrb, e.sop, e.eop, e.be, e.data, e.hdrb);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int pid, input int i);
    return 64'hDA7A_0000_0000_0000 | (64'(pid) << 16) | 64'(i);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_host);
      #1;
    end
  endtask

  // One packet of n beats; acc says whether it should come out, trunc_last forces eop on its last beat.
  task automatic send(input int pid, input int n, input bit with_eop, input bit acc,
                      input bit trunc_last, input logic [7:0] last_be);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_sop    = (i == 0);
      bus.in_eop    = with_eop && (i == n - 1);
      bus.in_byteen = (i == n - 1) ? last_be : 8'hFF;
      bus.in_data   = mk(pid, i);
      if (acc && i < MAXB) begin
        e.sop  = (i == 0);
        e.eop  = (with_eop && i == n - 1) || (i == MAXB - 1) || (trunc_last && i == n - 1);
        e.be   = bus.in_byteen;
        e.data = bus.in_data;
        e.hdrb = bus.in_headerB;
        exp_q.push_back(e);
      end
      @(posedge clk_host);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(1);
    check("drain_left", exp_q.size(), 0);
    idle(3);
    check("empty_after_drain", {31'd0, bus.out_valid}, 0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_accepted"},    cnt_accepted,    e_acc);
    check({tag, "_drop_filter"}, cnt_drop_filter, e_filt);
    check({tag, "_drop_full"},   cnt_drop_full,   e_full);
    check({tag, "_truncated"},   cnt_truncated,   e_trunc);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_byteen  = '0;
    bus.in_data    = '0;
    bus.in_headerA = '0;
    bus.in_headerB = '0;
    bus.out_ready  = 1'b1;
    cfg_match_en   = 1'b0;
    cfg_match_addr = '0;

    idle(3);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_out_data_lo", bus.out_data[31:0], 0);
    check("rst_fifo_level", fifo_level, 0);
    check_counters("rst");
    rst_n = 1'b1;
    idle(2);

    // filter off, 3 beats with a partial last beat
    bus.in_headerA = 48'h1122_3344_5566;
    bus.in_headerB = 32'hCAFE_0001;
    send(1, 3, 1, 1, 0, 8'h0F);
    e_acc++;
    drain();
    check_counters("t1");

    // address filter: mismatch dropped, broadcast and exact match accepted
    cfg_match_en   = 1'b1;
    cfg_match_addr = 48'h0A0B_0C0D_0E0F;
    bus.in_headerB = 32'hCAFE_0002;
    send(2, 3, 1, 0, 0, 8'hFF);
    e_filt++;
    bus.in_headerA = 48'hFFFF_FFFF_FFFF;
    bus.in_headerB = 32'hCAFE_0003;
    send(3, 2, 1, 1, 0, 8'h3F);
    e_acc++;
    bus.in_headerA = 48'h0A0B_0C0D_0E0F;
    bus.in_headerB = 32'hCAFE_0004;
    send(4, 1, 1, 1, 0, 8'h01);
    e_acc++;
    drain();
    check_counters("t2");
    cfg_match_en = 1'b0;

    // fill to 16 with ready low, third packet dropped for space
    bus.out_ready  = 1'b0;
    bus.in_headerB = 32'hCAFE_0005;
    send(5, 8, 1, 1, 0, 8'hFF);
    bus.in_headerB = 32'hCAFE_0006;
    send(6, 8, 1, 1, 0, 8'hFF);
    e_acc += 2;
    idle(2);
    check("t3_level_full", fifo_level, 16);
    send(7, 4, 1, 0, 0, 8'hFF);
    e_full++;
    idle(2);
    check("t3_level_after_drop", fifo_level, 16);
    check_counters("t3");
    bus.out_ready = 1'b1;
    drain();
    check("t3_level_drained", fifo_level, 0);

    // 10-beat packet truncated at 8
    bus.in_headerB = 32'hCAFE_0008;
    send(8, 10, 1, 1, 0, 8'hFF);
    e_acc++;
    e_trunc++;
    drain();
    check_counters("t4");

    // early sop cuts the previous packet at beat 2
    bus.in_headerB = 32'hCAFE_0009;
    send(9, 2, 0, 1, 1, 8'hFF);
    bus.in_headerB = 32'hCAFE_000A;
    send(10, 3, 1, 1, 0, 8'h07);
    e_acc += 2;
    e_trunc++;
    drain();
    check_counters("t5");

    // reset mid-packet with level 5
    bus.out_ready  = 1'b0;
    bus.in_headerB = 32'hCAFE_000B;
    send(11, 5, 0, 0, 0, 8'hFF);
    check("t6_level_pre", fifo_level, 5);
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", {31'd0, bus.out_valid}, 0);
    check("t6_level_rst", fifo_level, 0);
    exp_q.delete();
    e_acc = 0; e_filt = 0; e_full = 0; e_trunc = 0;
    check_counters("t6_rst");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    bus.out_ready  = 1'b1;
    bus.in_headerB = 32'hCAFE_000C;
    send(12, 2, 1, 1, 0, 8'hFF);
    e_acc++;
    drain();
    check_counters("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
